grad_update_sched: RTL and testbench



---
 rtl/grad_sched_pkg.sv | 14 +
 rtl/grad_rr_arb.sv | 28 ++
 rtl/grad_update_sched.sv | 168 ++++++++++++++++
 tb/tb_grad_update_sched.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_sched_pkg.sv
// Shared state type and default sizes for the gradient update scheduler.
package grad_sched_pkg;

    localparam int unsigned GRAD_SCHED_CH     = 4;
    localparam int unsigned GRAD_SCHED_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LDAC
    } grad_sched_state_t;

endpackage

// File: rtl/grad_rr_arb.sv
// Combinational round-robin picker: first pending slot after last_grant, wrapping mod CH.
module grad_rr_arb
    import grad_sched_pkg::*;
#(
    parameter int unsigned CH    = GRAD_SCHED_CH,
    parameter int unsigned IDX_W = $clog2(GRAD_SCHED_CH)
) (
    input  logic [CH-1:0]    pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int unsigned k;
        grant_valid = 1'b0;
        grant_idx   = '0;
        k           = 0;
        for (int unsigned i = 1; i <= CH; i++) begin
            k = (32'(last_grant) + i) % CH;
            if (!grant_valid && pending[k]) begin
                grant_valid = 1'b1;
                grant_idx   = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/grad_update_sched.sv
// Shares one gradient DAC serialiser between CH channel requesters (round-robin).
// Define GRAD_SCHED_LDAC_EN to emit a one-cycle load-DAC strobe after each burst.
module grad_update_sched
    import grad_sched_pkg::*;
#(
    parameter int unsigned CH     = GRAD_SCHED_CH,
    parameter int unsigned DATA_W = GRAD_SCHED_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*DATA_W-1:0]  req_data_i,
    input  logic [CH-1:0]         req_valid_i,
    output logic [DATA_W-1:0]     ser_data_o,
    output logic [$clog2(CH)-1:0] ser_ch_o,
    output logic                  ser_valid_o,
    input  logic                  ser_ready_i,
    output logic                  ldac_o,
    output logic [CH-1:0]         pending_o,
    output logic [CH-1:0]         overwrite_o,
    input  logic                  err_clr_i,
    output logic                  busy_o
);

    localparam int unsigned IDX_W = $clog2(CH);
`ifdef GRAD_SCHED_LDAC_EN
    localparam int unsigned CNT_W = $clog2(CH) + 1;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

    grad_sched_state_t state_q, state_d;
    logic [DATA_W-1:0] slot_q [CH];
    logic [DATA_W-1:0] slot_d [CH];
    logic [CH-1:0]     pending_q, pending_d;
    logic [CH-1:0]     overwrite_q, overwrite_d;
    logic [CH-1:0]     ovw_new;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  ser_ch_q, ser_ch_d;
    logic [DATA_W-1:0] ser_data_q, ser_data_d;
    logic              ser_valid_q, ser_valid_d;
    logic              grant_valid, do_grant, xfer, any_pend;
    logic [IDX_W-1:0]  grant_idx;

    grad_rr_arb #(
        .CH   (CH),
        .IDX_W(IDX_W)
    ) u_arb (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        ser_valid_d  = ser_valid_q;
        ser_data_d   = ser_data_q;
        ser_ch_d     = ser_ch_q;
        last_grant_d = last_grant_q;
        ovw_new      = '0;
`ifdef GRAD_SCHED_LDAC_EN
        burst_cnt_d  = burst_cnt_q;
`endif
        do_grant = ((state_q == IDLE) || (state_q == LOAD)) && grant_valid;
        xfer     = ser_valid_q && ser_ready_i;

        // A capture on the slot being granted this cycle is not an overwrite: the old word is the one loaded.
        for (int unsigned n = 0; n < CH; n++) begin
            if (req_valid_i[n]) begin
                slot_d[n] = req_data_i[n*DATA_W +: DATA_W];
                if (pending_q[n] && !(do_grant && (grant_idx == IDX_W'(n)))) begin
                    ovw_new[n] = 1'b1;
                end
            end
        end

        pending_d = pending_q;
        if (do_grant) begin
            pending_d[grant_idx] = 1'b0;
        end
        pending_d   = pending_d | req_valid_i;
        any_pend    = |pending_d;
        overwrite_d = (overwrite_q & ~{CH{err_clr_i}}) | ovw_new;

        // IDLE grants straight into SEND so the first word is presented the cycle after it is pending;
        // LOAD is the re-arbitration cycle that spaces back-to-back words two cycles apart.
        case (state_q)
            IDLE, LOAD: begin
                if (do_grant) begin
                    ser_data_d   = slot_q[grant_idx];
                    ser_ch_d     = grant_idx;
                    last_grant_d = grant_idx;
                    ser_valid_d  = 1'b1;
                    state_d      = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (xfer) begin
                    ser_valid_d = 1'b0;
`ifdef GRAD_SCHED_LDAC_EN
                    burst_cnt_d = (burst_cnt_q == CNT_W'(CH)) ? burst_cnt_q : burst_cnt_q + 1'b1;
                    if (any_pend) begin
                        state_d = LOAD;
                    end else if (burst_cnt_d != '0) begin
                        state_d = LDAC;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = any_pend ? LOAD : IDLE;
`endif
                end
            end
`ifdef GRAD_SCHED_LDAC_EN
            LDAC: begin
                burst_cnt_d = '0;
                state_d     = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            overwrite_q  <= '0;
            last_grant_q <= IDX_W'(CH - 1);
            ser_ch_q     <= '0;
            ser_data_q   <= '0;
            ser_valid_q  <= 1'b0;
            for (int unsigned n = 0; n < CH; n++) begin
                slot_q[n] <= '0;
            end
`ifdef GRAD_SCHED_LDAC_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overwrite_q  <= overwrite_d;
            last_grant_q <= last_grant_d;
            ser_ch_q     <= ser_ch_d;
            ser_data_q   <= ser_data_d;
            ser_valid_q  <= ser_valid_d;
            slot_q       <= slot_d;
`ifdef GRAD_SCHED_LDAC_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

    assign ser_data_o  = ser_data_q;
    assign ser_ch_o    = ser_ch_q;
    assign ser_valid_o = ser_valid_q;
    assign pending_o   = pending_q;
    assign overwrite_o = overwrite_q;
    assign busy_o      = (state_q != IDLE);
`ifdef GRAD_SCHED_LDAC_EN
    assign ldac_o      = (state_q == LDAC);
`else
    assign ldac_o      = 1'b0;
`endif

endmodule

// File: tb/tb_grad_update_sched.sv
// Scoreboarded bench for grad_update_sched: ordering, latency, overwrite, backpressure, reset.
module tb_grad_update_sched;
    import grad_sched_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*DW-1:0]  req_data;
    logic [CH-1:0]     req_valid;
    logic [DW-1:0]     ser_data;
    logic [1:0]        ser_ch;
    logic              ser_valid;
    logic              ser_ready;
    logic              ldac;
    logic [CH-1:0]     pending;
    logic [CH-1:0]     overwrite;
    logic              err_clr;
    logic              busy;

    always #5 clk = ~clk;

    grad_update_sched #(
        .CH    (CH),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_data_i (req_data),
        .req_valid_i(req_valid),
        .ser_data_o (ser_data),
        .ser_ch_o   (ser_ch),
        .ser_valid_o(ser_valid),
        .ser_ready_i(ser_ready),
        .ldac_o     (ldac),
        .pending_o  (pending),
        .overwrite_o(overwrite),
        .err_clr_i  (err_clr),
        .busy_o     (busy)
    );

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [1:0]    act_ch[$];
    logic [DW-1:0] act_data[$];
    int            act_cyc[$];
    int            ldac_cyc[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            exp_last = 3;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer happens at the coming posedge when valid & ready are seen here.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ser_valid && ser_ready) begin
                act_ch.push_back(ser_ch);
                act_data.push_back(ser_data);
                act_cyc.push_back(cyc);
            end
            if (ldac) ldac_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input int ch, input logic [DW-1:0] d);
        req_valid[ch]          = 1'b1;
        req_data[ch*DW +: DW]  = d;
    endtask

    task automatic push_exp(input int ch, input logic [DW-1:0] d, input int c);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic go_idle(output bit ok);
        for (int i = 0; i < 60 && (busy || pending != '0); i++) tick(1);
        ok = !busy && (pending == '0);
        act_ch.delete();
        act_data.delete();
        act_cyc.delete();
        ldac_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        ser_ready = 1'b0;
        err_clr   = 1'b0;
        tick(2);
        n_cmp++;
        if ({ser_valid, ldac, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got valid/ldac/busy=%b want 000", {ser_valid, ldac, busy});
        end
        n_cmp++;
        if ({ser_ch, ser_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got ch=%0d data=%h want 0/0", ser_ch, ser_data);
        end
        n_cmp++;
        if ({pending, overwrite} !== '0) begin
            n_bad++;
            $display("FAIL reset_flags: got pending=%b overwrite=%b want 0", pending, overwrite);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_all_four(input string name);
        bit ok;
        int c0, ch, ac;
        exp_t e;
        logic [1:0] ach;
        logic [DW-1:0] ad;
        ser_ready = 1'b1;
        go_idle(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_idle: got busy=%b pending=%b want idle", name, busy, pending); end
        c0 = cyc;
        for (int i = 0; i < 4; i++) req(i, DW'(24'h10 + i));
        for (int k = 0; k < 4; k++) begin
            ch = (exp_last + 1 + k) % 4;
            push_exp(ch, DW'(24'h10 + ch), c0 + 2 + 2 * k);
        end
        exp_last = (exp_last + 4) % 4;
        tick(1);
        req_valid = '0;
        tick(12);
        n_cmp++;
        if (act_ch.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s_count: got %0d transfers want %0d", name, act_ch.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_ch.size() > 0) begin
            e = exp_q.pop_front(); ach = act_ch.pop_front(); ad = act_data.pop_front(); ac = act_cyc.pop_front();
            n_cmp++;
            if (ach !== e.ch || ad !== e.data || ac != e.cyc) begin
                n_bad++;
                $display("FAIL %s_xfer: got ch%0d %h @%0d want ch%0d %h @%0d", name, ach, ad, ac, e.ch, e.data, e.cyc);
            end
        end
`ifdef GRAD_SCHED_LDAC_EN
        n_cmp++;
        if (ldac_cyc.size() != 1 || ldac_cyc[0] != c0 + 9) begin
            n_bad++;
            $display("FAIL %s_ldac: got %0d pulses first @%0d want 1 @%0d", name, ldac_cyc.size(), ldac_cyc[0], c0 + 9);
        end
`else
        n_cmp++;
        if (ldac_cyc.size() != 0) begin n_bad++; $display("FAIL %s_ldac: got %0d pulses want 0", name, ldac_cyc.size()); end
`endif
    endtask

    task automatic test_single();
        bit ok;
        int c0, ac;
        exp_t e;
        logic [1:0] ach;
        logic [DW-1:0] ad;
        ser_ready = 1'b1;
        go_idle(ok);
        c0 = cyc;
        req(2, 24'h123456);
        push_exp(2, 24'h123456, c0 + 2);
        exp_last = 2;
        tick(1);
        req_valid = '0;
        tick(6);
        n_cmp++;
        if (act_ch.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", act_ch.size()); end
        while (exp_q.size() > 0 && act_ch.size() > 0) begin
            e = exp_q.pop_front(); ach = act_ch.pop_front(); ad = act_data.pop_front(); ac = act_cyc.pop_front();
            n_cmp++;
            if (ach !== e.ch || ad !== e.data || ac != e.cyc) begin
                n_bad++;
                $display("FAIL single_xfer: got ch%0d %h @%0d want ch%0d %h @%0d", ach, ad, ac, e.ch, e.data, e.cyc);
            end
        end
`ifdef GRAD_SCHED_LDAC_EN
        n_cmp++;
        if (ldac_cyc.size() != 1 || ldac_cyc[0] != c0 + 3) begin
            n_bad++;
            $display("FAIL single_ldac: got %0d pulses @%0d want 1 @%0d", ldac_cyc.size(), ldac_cyc[0], c0 + 3);
        end
`else
        n_cmp++;
        if (ldac_cyc.size() != 0) begin n_bad++; $display("FAIL single_ldac: got %0d pulses want 0", ldac_cyc.size()); end
`endif
    endtask

    task automatic test_overwrite();
        bit ok;
        int r, ac;
        exp_t e;
        logic [1:0] ach;
        logic [DW-1:0] ad;
        ser_ready = 1'b0;
        go_idle(ok);
        req(0, 24'h0C0D0E);
        tick(1);
        req_valid = '0;
        for (int i = 0; i < 10 && !ser_valid; i++) tick(1);
        req(1, 24'hAAAAAA);
        tick(1);
        req(1, 24'hBBBBBB);
        tick(1);
        req_valid = '0;
        n_cmp++;
        if (overwrite !== 4'b0010 || pending !== 4'b0010) begin
            n_bad++;
            $display("FAIL ovw_set: got overwrite=%b pending=%b want 0010/0010", overwrite, pending);
        end
        req(1, 24'hBBBBBB);
        err_clr = 1'b1;
        tick(1);
        req_valid = '0;
        n_cmp++;
        if (overwrite !== 4'b0010) begin n_bad++; $display("FAIL ovw_clr_race: got %b want 0010", overwrite); end
        tick(1);
        err_clr = 1'b0;
        n_cmp++;
        if (overwrite !== 4'b0000) begin n_bad++; $display("FAIL ovw_clear: got %b want 0000", overwrite); end
        ser_ready = 1'b1;
        r = cyc;
        push_exp(0, 24'h0C0D0E, r);
        push_exp(1, 24'hBBBBBB, r + 2);
        tick(6);
        n_cmp++;
        if (act_ch.size() != 2) begin n_bad++; $display("FAIL ovw_count: got %0d want 2", act_ch.size()); end
        while (exp_q.size() > 0 && act_ch.size() > 0) begin
            e = exp_q.pop_front(); ach = act_ch.pop_front(); ad = act_data.pop_front(); ac = act_cyc.pop_front();
            n_cmp++;
            if (ach !== e.ch || ad !== e.data || ac != e.cyc) begin
                n_bad++;
                $display("FAIL ovw_xfer: got ch%0d %h @%0d want ch%0d %h @%0d", ach, ad, ac, e.ch, e.data, e.cyc);
            end
        end
`ifdef GRAD_SCHED_LDAC_EN
        n_cmp++;
        if (ldac_cyc.size() != 1 || ldac_cyc[0] != r + 3) begin
            n_bad++;
            $display("FAIL ovw_ldac: got %0d pulses @%0d want 1 @%0d", ldac_cyc.size(), ldac_cyc[0], r + 3);
        end
`else
        n_cmp++;
        if (ldac_cyc.size() != 0) begin n_bad++; $display("FAIL ovw_ldac: got %0d pulses want 0", ldac_cyc.size()); end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        int c0, r, ac;
        exp_t e;
        logic [1:0] ach;
        logic [DW-1:0] ad;
        ser_ready = 1'b0;
        go_idle(ok);
        c0 = cyc;
        req(3, 24'h3C3C3C);
        tick(1);
        req_valid = '0;
        for (int i = 0; i < 10 && !ser_valid; i++) tick(1);
        n_cmp++;
        if (cyc != c0 + 2) begin n_bad++; $display("FAIL bp_latency: got valid @%0d want @%0d", cyc, c0 + 2); end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_cmp++;
            if ({ser_valid, ser_ch, ser_data} !== {1'b1, 2'd3, 24'h3C3C3C}) begin
                n_bad++;
                $display("FAIL bp_hold: got v=%b ch%0d %h want v=1 ch3 3c3c3c", ser_valid, ser_ch, ser_data);
            end
        end
        ser_ready = 1'b1;
        r = cyc;
        push_exp(3, 24'h3C3C3C, r);
        exp_last = 3;
        tick(4);
        n_cmp++;
        if (act_ch.size() != 1) begin n_bad++; $display("FAIL bp_count: got %0d want 1", act_ch.size()); end
        while (exp_q.size() > 0 && act_ch.size() > 0) begin
            e = exp_q.pop_front(); ach = act_ch.pop_front(); ad = act_data.pop_front(); ac = act_cyc.pop_front();
            n_cmp++;
            if (ach !== e.ch || ad !== e.data || ac != e.cyc) begin
                n_bad++;
                $display("FAIL bp_xfer: got ch%0d %h @%0d want ch%0d %h @%0d", ach, ad, ac, e.ch, e.data, e.cyc);
            end
        end
    endtask

    task automatic test_reset_in_send();
        bit ok;
        int c0, ac;
        exp_t e;
        logic [1:0] ach;
        logic [DW-1:0] ad;
        ser_ready = 1'b0;
        go_idle(ok);
        req(1, 24'h111111);
        tick(1);
        req_valid = '0;
        for (int i = 0; i < 10 && !ser_valid; i++) tick(1);
        rst_n = 1'b0;
        tick(1);
        n_cmp++;
        if ({ser_valid, ldac, busy, ser_ch, ser_data, pending, overwrite} !== '0) begin
            n_bad++;
            $display("FAIL rst_send: got v=%b busy=%b ch%0d %h pend=%b want all 0", ser_valid, busy, ser_ch, ser_data, pending);
        end
        rst_n = 1'b1;
        exp_last = 3;
        tick(1);
        ser_ready = 1'b1;
        c0 = cyc;
        req(3, 24'h0F0F0F);
        push_exp(3, 24'h0F0F0F, c0 + 2);
        tick(1);
        req_valid = '0;
        tick(6);
        n_cmp++;
        if (act_ch.size() != 1) begin n_bad++; $display("FAIL rst_count: got %0d want 1", act_ch.size()); end
        while (exp_q.size() > 0 && act_ch.size() > 0) begin
            e = exp_q.pop_front(); ach = act_ch.pop_front(); ad = act_data.pop_front(); ac = act_cyc.pop_front();
            n_cmp++;
            if (ach !== e.ch || ad !== e.data || ac != e.cyc) begin
                n_bad++;
                $display("FAIL rst_xfer: got ch%0d %h @%0d want ch%0d %h @%0d", ach, ad, ac, e.ch, e.data, e.cyc);
            end
        end
    endtask

    // gap 2: second request lands on the transfer edge (in flight); gap 1: on the grant edge.
    task automatic test_rerequest(input int gap, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        bit ok;
        int c0, ac;
        exp_t e;
        logic [1:0] ach;
        logic [DW-1:0] ad;
        ser_ready = 1'b1;
        go_idle(ok);
        c0 = cyc;
        req(0, d1);
        tick(1);
        req_valid = '0;
        tick(gap - 1);
        req(0, d2);
        tick(1);
        req_valid = '0;
        n_cmp++;
        if (overwrite !== 4'b0000) begin n_bad++; $display("FAIL rereq%0d_ovw: got %b want 0000", gap, overwrite); end
        push_exp(0, d1, c0 + 2);
        push_exp(0, d2, c0 + 4);
        exp_last = 0;
        tick(6);
        n_cmp++;
        if (act_ch.size() != 2) begin n_bad++; $display("FAIL rereq%0d_count: got %0d want 2", gap, act_ch.size()); end
        while (exp_q.size() > 0 && act_ch.size() > 0) begin
            e = exp_q.pop_front(); ach = act_ch.pop_front(); ad = act_data.pop_front(); ac = act_cyc.pop_front();
            n_cmp++;
            if (ach !== e.ch || ad !== e.data || ac != e.cyc) begin
                n_bad++;
                $display("FAIL rereq%0d_xfer: got ch%0d %h @%0d want ch%0d %h @%0d", gap, ach, ad, ac, e.ch, e.data, e.cyc);
            end
        end
`ifdef GRAD_SCHED_LDAC_EN
        n_cmp++;
        if (ldac_cyc.size() != 1 || ldac_cyc[0] != c0 + 5) begin
            n_bad++;
            $display("FAIL rereq%0d_ldac: got %0d pulses @%0d want 1 @%0d", gap, ldac_cyc.size(), ldac_cyc[0], c0 + 5);
        end
`else
        n_cmp++;
        if (ldac_cyc.size() != 0) begin n_bad++; $display("FAIL rereq%0d_ldac: got %0d pulses want 0", gap, ldac_cyc.size()); end
`endif
    endtask

    initial begin
        test_reset();
        test_all_four("burst1");
        test_all_four("burst2");
        test_single();
        test_overwrite();
        test_backpressure();
        test_reset_in_send();
        test_rerequest(2, 24'hA0A0A0, 24'hA1A1A1);
        test_rerequest(1, 24'hE1E1E1, 24'hE2E2E2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
